// File: rtl/countdown_timer_pkg.sv
// Shared constants for the MM:SS BCD countdown timer.
`ifndef COUNTDOWN_TIMER_PKG_SV
`define COUNTDOWN_TIMER_PKG_SV

package countdown_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_ALARM = 2'b11
   } state_t;

   localparam logic [3:0]  TENS_MAX  = 4'd5;
   localparam logic [3:0]  ONES_MAX  = 4'd9;
   localparam logic [3:0]  BCD_ZERO  = 4'd0;
   localparam logic [15:0] TIME_ZERO = 16'h0000;
   localparam logic [15:0] TIME_ONE  = 16'h0001;

   // Clamp a load value to the digit's maximum.
   function automatic logic [3:0] sat_digit(input logic [3:0] val, input logic [3:0] max);
      return (val > max) ? max : val;
   endfunction

endpackage

`endif

// File: rtl/countdown_timer_digit.sv
// Single BCD down-counting digit with load, borrow-in and borrow-out.
module bcd_down_digit
   import countdown_timer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] init,
   input  logic       dec,
   input  logic [3:0] max,
   output logic [3:0] digit,
   output logic       bout
);

   // Load wins over a decrement; a decrement from zero wraps to max.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         digit <= BCD_ZERO;
      end else if (load) begin
         digit <= sat_digit(init, max);
      end else if (dec) begin
         if (digit == BCD_ZERO) digit <= max;
         else                   digit <= digit - 4'd1;
      end
   end

   // Borrow into the next digit up whenever this one wraps.
   always_comb begin
      bout = dec && (digit == BCD_ZERO);
   end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with pause, expiry pulse and timed alarm.
//
//  state    | meaning
//  ---------+------------------------------------------------------
//  ST_IDLE  | loaded or expired, waiting for start_resume
//  ST_RUN   | counting down one second per tick
//  ST_PAUSE | digits held until start_resume returns with stop low
//  ST_ALARM | reached 00:00, alarm high for ALARM_TICKS ticks
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int ALARM_TICKS  = 10,
   parameter int SEC_TENS_MAX = 5,
   parameter int ONES_MAX_P   = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       set,
   input  logic       start_resume,
   input  logic       stop,
   input  logic [3:0] init_min_tens,
   input  logic [3:0] init_min_ones,
   input  logic [3:0] init_sec_tens,
   input  logic [3:0] init_sec_ones,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       done,
   output logic       alarm
);

   localparam logic [3:0] TENS_LIM   = 4'(SEC_TENS_MAX);
   localparam logic [3:0] ONES_LIM   = 4'(ONES_MAX_P);
   localparam logic [3:0] ALARM_LOAD = 4'(ALARM_TICKS);

   state_t      state_q, state_d;
   logic [3:0]  alarm_cnt_q;
   logic        dec_en;
   logic        so_bout, st_bout, mo_bout, mt_bout;
   logic [15:0] digits;
   logic        at_zero, at_one;

   assign digits  = {min_tens, min_ones, sec_tens, sec_ones};
   assign at_zero = (digits == TIME_ZERO);
   assign at_one  = (digits == TIME_ONE);

   bcd_down_digit u_sec_ones (
      .clk   (clk),
      .reset (reset),
      .load  (set),
      .init  (init_sec_ones),
      .dec   (dec_en),
      .max   (ONES_LIM),
      .digit (sec_ones),
      .bout  (so_bout)
   );

   bcd_down_digit u_sec_tens (
      .clk   (clk),
      .reset (reset),
      .load  (set),
      .init  (init_sec_tens),
      .dec   (so_bout),
      .max   (TENS_LIM),
      .digit (sec_tens),
      .bout  (st_bout)
   );

   bcd_down_digit u_min_ones (
      .clk   (clk),
      .reset (reset),
      .load  (set),
      .init  (init_min_ones),
      .dec   (st_bout),
      .max   (ONES_LIM),
      .digit (min_ones),
      .bout  (mo_bout)
   );

   bcd_down_digit u_min_tens (
      .clk   (clk),
      .reset (reset),
      .load  (set),
      .init  (init_min_tens),
      .dec   (mo_bout),
      .max   (TENS_LIM),
      .digit (min_tens),
      .bout  (mt_bout)
   );

   // State, alarm counter and registered done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         alarm_cnt_q <= 4'd0;
         done        <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= (state_q == ST_RUN) && (state_d == ST_ALARM);
         if (set) begin
            alarm_cnt_q <= 4'd0;
         end else if ((state_q == ST_RUN) && (state_d == ST_ALARM)) begin
            alarm_cnt_q <= ALARM_LOAD;
         end else if (state_q == ST_ALARM) begin
            if (stop)                              alarm_cnt_q <= 4'd0;
            else if (tick && alarm_cnt_q != 4'd0) alarm_cnt_q <= alarm_cnt_q - 4'd1;
         end
      end
   end

   // Next state: set > stop > start_resume > tick.
   always_comb begin
      state_d = state_q;
      if (set) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (!stop && start_resume && !at_zero) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (stop || !start_resume) state_d = ST_PAUSE;
               // A borrow out of the top digit could only mean the count
               // passed zero; treat it as expiry rather than wrapping.
               else if (tick && (at_one || mt_bout)) state_d = ST_ALARM;
            end
            ST_PAUSE: begin
               if (!stop && start_resume) state_d = ST_RUN;
            end
            ST_ALARM: begin
               if (stop) state_d = ST_IDLE;
               else if (tick && alarm_cnt_q <= 4'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Status outputs and the decrement enable for the digit chain.
   always_comb begin
      running = (state_q == ST_RUN);
      alarm   = (state_q == ST_ALARM);
      dec_en  = (state_q == ST_RUN) && !set && !stop && start_resume && tick && !at_zero;
   end

endmodule
